// File: rtl/satatx_stream_arb.sv
// Packet arbiter sharing the SATA TX scrambler between a control-FIS source (S0)
// and a data-FIS source (S1); one packet at a time, with per-packet scrambler enable.
module satatx_stream_arb #(
  parameter bit OPT_LOWPOWER = 1'b1,
  parameter int LGMAXLEN     = 12
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_cfg_scrambler_en,
  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [31:0] S0_AXIS_TDATA,
  input  logic        S0_AXIS_TLAST,
  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  input  logic [31:0] S1_AXIS_TDATA,
  input  logic        S1_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic        o_scrambler_en,
  output logic [1:0]  o_grant,
  output logic        o_overflow
);
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  // Counter value just before the beat that reaches the limit.
  localparam logic [LGMAXLEN:0] LASTCNT = {1'b0, {LGMAXLEN{1'b1}}};

  state_t            state_q, state_d;
  logic              g_q, g_d, r_q, r_d;
  logic [LGMAXLEN:0] cnt_q, cnt_d;
  logic              en_q, en_d, ovf_q, ovf_d;
  logic              mvalid_q, mvalid_d, mlast_q, mlast_d;
  logic [31:0]       mdata_q, mdata_d;
  logic              sv, sl, m_free, rdy, win;
  logic [31:0]       sd;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      g_q      <= 1'b0;
      r_q      <= 1'b1;
      cnt_q    <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mlast_q  <= mlast_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    g_d      = g_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    ovf_d    = 1'b0;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    rdy      = 1'b0;
    win      = 1'b0;
    sv       = g_q ? S1_AXIS_TVALID : S0_AXIS_TVALID;
    sd       = g_q ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
    sl       = g_q ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
    m_free   = !mvalid_q || M_AXIS_TREADY;

    if (m_free) begin
      mvalid_d = 1'b0;
      if (OPT_LOWPOWER) begin
        mdata_d = '0;
        mlast_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        // Hold off while the previous packet's last beat is stalled so the
        // scrambler enable cannot change under it.
        if (m_free && (S0_AXIS_TVALID || S1_AXIS_TVALID)) begin
          win     = (S0_AXIS_TVALID && S1_AXIS_TVALID) ? !r_q : S1_AXIS_TVALID;
          g_d     = win;
          r_d     = win;
          en_d    = i_cfg_scrambler_en;
          cnt_d   = '0;
          state_d = PASS;
        end
      end
      PASS: begin
        rdy = m_free;
        if (sv && m_free) begin
          mvalid_d = 1'b1;
          mdata_d  = sd;
          mlast_d  = sl || (cnt_q == LASTCNT);
          cnt_d    = cnt_q + 1'b1;
          if (sl) begin
            state_d = IDLE;
          end else if (cnt_q == LASTCNT) begin
            ovf_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        rdy = 1'b1;
        if (sv && sl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign S0_AXIS_TREADY = rdy && !g_q;
  assign S1_AXIS_TREADY = rdy && g_q;
  assign M_AXIS_TVALID  = mvalid_q;
  assign M_AXIS_TDATA   = mdata_q;
  assign M_AXIS_TLAST   = mlast_q;
  assign o_scrambler_en = en_q;
  assign o_grant        = (state_q == IDLE) ? 2'b00 : {g_q, !g_q};
  assign o_overflow     = ovf_q;
endmodule

// File: tb/tb_satatx_stream_arb.sv
// Directed bench for satatx_stream_arb (built with an 8-beat limit so
// truncation and the exact-limit boundary are cheap to reach).
module tb_satatx_stream_arb;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg;
  logic        S0_TVALID, S0_TREADY, S0_TLAST, S1_TVALID, S1_TREADY, S1_TLAST;
  logic [31:0] S0_TDATA, S1_TDATA, M_TDATA;
  logic        M_TVALID, M_TREADY, M_TLAST, scr_en, ovf;
  logic [1:0]  grant;

  always #5 clk = ~clk;

  satatx_stream_arb #(.OPT_LOWPOWER(1'b1), .LGMAXLEN(3)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rstn), .i_cfg_scrambler_en(cfg),
    .S0_AXIS_TVALID(S0_TVALID), .S0_AXIS_TREADY(S0_TREADY),
    .S0_AXIS_TDATA(S0_TDATA), .S0_AXIS_TLAST(S0_TLAST),
    .S1_AXIS_TVALID(S1_TVALID), .S1_AXIS_TREADY(S1_TREADY),
    .S1_AXIS_TDATA(S1_TDATA), .S1_AXIS_TLAST(S1_TLAST),
    .M_AXIS_TVALID(M_TVALID), .M_AXIS_TREADY(M_TREADY),
    .M_AXIS_TDATA(M_TDATA), .M_AXIS_TLAST(M_TLAST),
    .o_scrambler_en(scr_en), .o_grant(grant), .o_overflow(ovf));

  typedef struct packed {logic [31:0] d; logic l;} beat_t;
  typedef struct {logic [31:0] d; logic l; int cyc; logic en;} obeat_t;

  beat_t      s0q[$], s1q[$];
  bit         rdyq[$];
  obeat_t     outq[$];
  logic [1:0] ghist[int];
  int cyc = 0, pops0 = 0, pops1 = 0, ovf_cnt = 0, stable_err = 0;
  int checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source/sink model: handshakes are decided at the falling edge, queues
  // advance just after the rising edge.
  initial begin
    bit hs0, hs1, prev_stall;
    logic [31:0] pd;
    logic pl;
    beat_t b;
    prev_stall = 0; pd = '0; pl = 0;
    S0_TVALID = 0; S0_TDATA = '0; S0_TLAST = 0;
    S1_TVALID = 0; S1_TDATA = '0; S1_TLAST = 0;
    M_TREADY = 1;
    forever begin
      @(negedge clk);
      hs0 = S0_TVALID && S0_TREADY;
      hs1 = S1_TVALID && S1_TREADY;
      if (M_TVALID && M_TREADY) outq.push_back('{M_TDATA, M_TLAST, cyc, scr_en});
      if (prev_stall && (!M_TVALID || M_TDATA !== pd || M_TLAST !== pl)) stable_err++;
      prev_stall = M_TVALID && !M_TREADY;
      pd = M_TDATA; pl = M_TLAST;
      if (ovf) ovf_cnt++;
      ghist[cyc] = grant;
      @(posedge clk); #1;
      if (hs0 && s0q.size() > 0) begin b = s0q.pop_front(); pops0++; end
      if (hs1 && s1q.size() > 0) begin b = s1q.pop_front(); pops1++; end
      if (rdyq.size() > 0) M_TREADY = rdyq.pop_front(); else M_TREADY = 1;
      S0_TVALID = s0q.size() > 0;
      S0_TDATA  = (s0q.size() > 0) ? s0q[0].d : '0;
      S0_TLAST  = (s0q.size() > 0) ? s0q[0].l : 1'b0;
      S1_TVALID = s1q.size() > 0;
      S1_TDATA  = (s1q.size() > 0) ? s1q[0].d : '0;
      S1_TLAST  = (s1q.size() > 0) ? s1q[0].l : 1'b0;
    end
  end

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (s0q.size() == 0 && s1q.size() == 0 && rdyq.size() == 0 &&
          !M_TVALID && grant == 2'b00) begin
        ok = 1;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 0; cfg = 1;
    repeat (3) @(negedge clk);
    checks++; if (M_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", M_TVALID); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b want 00", grant); end
    checks++; if ({S0_TREADY, S1_TREADY} !== 2'b00) begin errors++; $display("FAIL reset_tready got %b want 00", {S0_TREADY, S1_TREADY}); end
    checks++; if ({ovf, scr_en} !== 2'b00) begin errors++; $display("FAIL reset_ovf_en got %b want 00", {ovf, scr_en}); end
    checks++; if ({M_TDATA, M_TLAST} !== 33'd0) begin errors++; $display("FAIL reset_data got %h/%b want 0/0", M_TDATA, M_TLAST); end
    rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_tie(input logic [31:0] base);
    bit ok;
    logic [31:0] exp_d [4];
    outq.delete();
    exp_d = '{base, base + 1, base + 32'h100, base + 32'h101};
    s0q.push_back('{base, 1'b0});          s0q.push_back('{base + 1, 1'b1});
    s1q.push_back('{base + 32'h100, 1'b0}); s1q.push_back('{base + 32'h101, 1'b1});
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_timeout got busy want idle"); end
    checks++; if (outq.size() != 4) begin errors++; $display("FAIL tie_count got %0d want 4", outq.size()); end
    for (int i = 0; i < 4 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== exp_d[i] || outq[i].l !== logic'(i[0])) begin
        errors++; $display("FAIL tie_beat%0d got %h/%b want %h/%b", i, outq[i].d, outq[i].l, exp_d[i], i[0]);
      end
    end
    if (outq.size() == 4) begin
      checks++;
      if (outq[2].cyc - outq[1].cyc != 2) begin
        errors++; $display("FAIL tie_bubble got gap %0d want 2", outq[2].cyc - outq[1].cyc);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    int n;
    outq.delete(); cfg = 1;
    for (int i = 0; i < 3; i++) s0q.push_back('{32'hA0A0_0000 + i, i == 2});
    n = cyc + 1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got busy want idle"); end
    checks++; if (outq.size() != 3) begin errors++; $display("FAIL single_count got %0d want 3", outq.size()); end
    for (int i = 0; i < 3 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== 32'hA0A0_0000 + i || outq[i].l !== (i == 2) ||
          outq[i].cyc != n + 2 + i || outq[i].en !== 1'b1) begin
        errors++; $display("FAIL single_beat%0d got %h/%b@%0d en%b want %h/%b@%0d en1",
          i, outq[i].d, outq[i].l, outq[i].cyc, outq[i].en, 32'hA0A0_0000 + i, i == 2, n + 2 + i);
      end
    end
    for (int c = n; c <= n + 4; c++) begin
      checks++;
      if (ghist[c] !== ((c >= n + 1 && c <= n + 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL single_grant@%0d got %b want %b", c - n, ghist[c],
          (c >= n + 1 && c <= n + 3) ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_cfg_change();
    bit ok;
    int ovf0;
    outq.delete(); cfg = 1; ovf0 = ovf_cnt; pops1 = 0;
    for (int i = 0; i < 8; i++) s1q.push_back('{32'hD100_0000 + i, i == 7});
    for (int i = 0; i < 100 && pops1 < 4; i++) @(negedge clk);
    cfg = 0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cfg_timeout got busy want idle"); end
    checks++; if (outq.size() != 8) begin errors++; $display("FAIL cfg_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== 32'hD100_0000 + i || outq[i].l !== (i == 7) || outq[i].en !== 1'b1) begin
        errors++; $display("FAIL cfg_beat%0d got %h/%b en%b want %h/%b en1",
          i, outq[i].d, outq[i].l, outq[i].en, 32'hD100_0000 + i, i == 7);
      end
    end
    checks++; if (ovf_cnt != ovf0) begin errors++; $display("FAIL exact_limit_ovf got %0d want 0", ovf_cnt - ovf0); end
    outq.delete();
    s0q.push_back('{32'hC0DE_0001, 1'b1});
    wait_done(ok);
    checks++;
    if (outq.size() != 1 || outq[0].en !== 1'b0 || outq[0].d !== 32'hC0DE_0001) begin
      errors++; $display("FAIL cfg_next_en got n=%0d en=%b want n=1 en=0", outq.size(),
        (outq.size() > 0) ? outq[0].en : 1'bx);
    end
    cfg = 1;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] exp_d [6];
    outq.delete(); stable_err = 0; pops0 = 0;
    for (int i = 0; i < 5; i++) begin
      s0q.push_back('{32'hB0B0_0000 + i, i == 4});
      exp_d[i] = 32'hB0B0_0000 + i;
    end
    exp_d[5] = 32'hE1E1_0000;
    rdyq = '{1, 1, 1, 0, 0, 1};
    for (int i = 0; i < 100 && pops0 < 1; i++) @(negedge clk);
    s1q.push_back('{32'hE1E1_0000, 1'b1});
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got busy want idle"); end
    checks++; if (outq.size() != 6) begin errors++; $display("FAIL bp_count got %0d want 6", outq.size()); end
    for (int i = 0; i < 6 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== exp_d[i] || outq[i].l !== (i >= 4)) begin
        errors++; $display("FAIL bp_beat%0d got %h/%b want %h/%b", i, outq[i].d, outq[i].l, exp_d[i], i >= 4);
      end
    end
    checks++; if (stable_err != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stable_err); end
  endtask

  task automatic test_overflow();
    bit ok;
    int ovf0;
    outq.delete(); ovf0 = ovf_cnt; pops0 = 0;
    for (int i = 0; i < 11; i++) s0q.push_back('{32'h0F00_0000 + i, i == 10});
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got busy want idle"); end
    checks++; if (outq.size() != 8) begin errors++; $display("FAIL ovf_count got %0d want 8", outq.size()); end
    for (int i = 0; i < 8 && i < outq.size(); i++) begin
      checks++;
      if (outq[i].d !== 32'h0F00_0000 + i || outq[i].l !== (i == 7)) begin
        errors++; $display("FAIL ovf_beat%0d got %h/%b want %h/%b", i, outq[i].d, outq[i].l, 32'h0F00_0000 + i, i == 7);
      end
    end
    checks++; if (ovf_cnt - ovf0 != 1) begin errors++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - ovf0); end
    checks++; if (pops0 != 11) begin errors++; $display("FAIL ovf_consumed got %0d want 11", pops0); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ovf_idle got %b want 00", grant); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lasts;
    outq.delete(); pops0 = 0; lasts = 0;
    for (int i = 0; i < 4; i++) s0q.push_back('{32'h5E5E_0000 + i, i == 3});
    for (int i = 0; i < 100 && pops0 < 2; i++) @(negedge clk);
    s0q.delete();
    rstn = 0;
    @(negedge clk);
    checks++; if (M_TVALID !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid got %b want 0", M_TVALID); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rstmid_grant got %b want 00", grant); end
    checks++; if ({S0_TREADY, S1_TREADY} !== 2'b00) begin errors++; $display("FAIL rstmid_tready got %b want 00", {S0_TREADY, S1_TREADY}); end
    rstn = 1;
    repeat (3) @(negedge clk);
    foreach (outq[i]) if (outq[i].l) lasts++;
    checks++; if (lasts != 0) begin errors++; $display("FAIL rstmid_tlast got %0d want 0", lasts); end
    outq.delete();
    s0q.push_back('{32'hF2E5_0000, 1'b0}); s0q.push_back('{32'hF2E5_0001, 1'b1});
    wait_done(ok);
    checks++;
    if (!ok || outq.size() != 2 || outq[0].d !== 32'hF2E5_0000 || outq[0].l !== 1'b0 ||
        outq[1].d !== 32'hF2E5_0001 || outq[1].l !== 1'b1) begin
      errors++; $display("FAIL rstmid_fresh got n=%0d ok=%0d want n=2 intact", outq.size(), ok);
    end
  endtask

  initial begin
    rstn = 0; cfg = 1;
    test_reset();
    test_tie(32'h7100_0000);
    test_tie(32'h7200_0000);
    test_single();
    test_cfg_change();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/satatx_stream_arb.md
# satatx_stream_arb

Packet-level arbiter that shares the single SATA TX scrambler datapath between two AXI-stream FIS sources: command/control FISes on port 0 and DATA FIS payload on port 1. It grants one source at a time and holds that grant until the packet's TLAST. It latches the scrambler enable once per packet, so a configuration change never takes effect mid-frame. It enforces a maximum FIS length, truncating and draining runaway packets. The block sits directly upstream of the TX scrambler, whose fill resets on every TLAST; packets must therefore never interleave.

## Interface
- OPT_LOWPOWER, 1'b1: zero M_AXIS_TDATA/TLAST whenever M_AXIS_TVALID is low.
- LGMAXLEN, 12: log2 of the beat limit; the limit is MAXLEN = 2^LGMAXLEN = 4096 beats. Every legal SATA FIS (≤ 2049 dwords) is under this limit.
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  reset; one clock; reset is synchronous and active-low.
- i_cfg_scrambler_en  in  1  requested scrambler enable; sampled only at grant.
- S0_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  source 0 (control FIS).
- S1_AXIS_TVALID/TREADY/TDATA/TLAST  in/out/in/in  1/1/32/1  source 1 (data FIS).
- M_AXIS_TVALID/TREADY/TDATA/TLAST  out/in/out/out  1/1/32/1  to the scrambler.
- o_scrambler_en  out  1  per-packet latched enable; drives the scrambler's i_cfg_scrambler_en.
- o_grant  out  2  one-hot current grant; 2'b00 when idle.
- o_overflow  out  1  one-cycle pulse when a packet is truncated.

## Operation
- States: IDLE, PASS, DRAIN. A registered grant index g ∈ {0,1} and a last-served bit r track the arbitration.
- IDLE, no valid input: stay in IDLE; o_grant=0.
- IDLE, any valid input: choose the winner.
  - Only one source valid: that source wins.
  - Both valid: round-robin; the source ≠ r wins. After reset r=1, so source 0 wins the first tie.
  - On the winner: set g, set r=g, latch o_scrambler_en <= i_cfg_scrambler_en, clear the beat counter, go to PASS.
  - No beat is accepted in the decision cycle.
- PASS:
  - Sx_AXIS_TREADY = (x==g) && (!M_AXIS_TVALID || M_AXIS_TREADY). The non-granted source's TREADY is 0.
  - Each accepted beat is registered to M_AXIS with TDATA/TLAST unchanged and increments the counter, width LGMAXLEN+1.
- PASS, accepted beat with TLAST: go to IDLE. The next arbitration happens in the following cycle, so there is exactly one bubble cycle between packets.
- PASS, accepted beat is number MAXLEN without TLAST:
  - Emit that beat with M_AXIS_TLAST forced to 1.
  - Pulse o_overflow.
  - Go to DRAIN.
- DRAIN:
  - Sg_AXIS_TREADY=1 unconditionally; beats are discarded and M_AXIS_TVALID is not raised by them.
  - On an accepted TLAST, go to IDLE.
- o_scrambler_en remains constant from grant until the cycle after the last M_AXIS beat is accepted.
  - Because M_AXIS is registered, the next grant's latch happens no earlier than the last beat's presentation. The latch must be held until M_AXIS_TVALID drops or its TLAST beat handshakes.
  - Implementation rule: arbitration from IDLE is blocked while M_AXIS_TVALID && !M_AXIS_TREADY.
- Output register follows the standard AXI-stream rule: while M_AXIS_TVALID && !M_AXIS_TREADY, TDATA and TLAST are held stable.

## Timing
- Reset values:
  - state=IDLE, r=1, counter=0.
  - M_AXIS_TVALID=0 and o_grant=0.
  - o_overflow=0 and o_scrambler_en=0.
  - M_AXIS_TDATA=0 and M_AXIS_TLAST=0 when OPT_LOWPOWER.
  - S0_AXIS_TREADY=S1_AXIS_TREADY=0.
- Latency:
  - Source TVALID arrives in IDLE at cycle n: grant at n+1, first beat accepted at n+1 (TREADY asserted from the grant register), M_AXIS_TVALID at n+2.
  - Steady state: 1 beat/cycle, with 1-cycle latency, S to M.
- Reset mid-packet: everything returns to reset values the next cycle. The in-flight packet is abandoned; no TLAST is emitted for it.
- TLAST on beat MAXLEN exactly: a normal end, with no overflow pulse and no DRAIN.
- Simultaneous requests on the cycle a packet ends: resolved in the next IDLE cycle by round-robin against the updated r.
- Sources must not drop TVALID, or change TDATA/TLAST, while stalled. The bench enforces this; the RTL does not check it.

## Test plan
- Single packet: S0 sends 3 beats A0,A1,A2 (TLAST on A2), M_AXIS_TREADY=1, cfg_en=1.
  - M shows A0..A2 at cycles n+2..n+4, TLAST on A2.
  - o_grant=01 from n+1 to n+3; o_scrambler_en=1.
- Tie: S0 and S1 each hold a 2-beat packet, valid from the same cycle.
  - Order out is S0 packet, one bubble, S1 packet.
  - Repeat the tie: order out is S0 then S1 again, i.e. strict alternation.
- Config change mid-packet: S1 sends 8 beats; toggle i_cfg_scrambler_en 1→0 at beat 4.
  - o_scrambler_en stays 1 through the TLAST beat.
  - Next packet is granted with o_scrambler_en=0.
- Backpressure: M_AXIS_TREADY toggles 1,0,0,1 during a 5-beat packet.
  - No beat is lost or duplicated, and TDATA is stable while stalled.
  - The other source is never granted before the TLAST handshake.
- Overflow with LGMAXLEN=3: S0 sends 11 beats.
  - M receives exactly 8 beats, with TLAST forced on beat 8.
  - o_overflow pulses once; beats 9–11 are consumed silently; state returns to IDLE.
- Reset at beat 2 of a 4-beat packet:
  - Next cycle: M_AXIS_TVALID=0, o_grant=00, all TREADY=0.
  - A subsequent fresh packet passes intact.
